// File: rtl/energy_telemetry_rx.sv
// -----------------------------------------------------------------------------
// energy_telemetry_rx
//
// Host-side receiver for the converter's telemetry byte stream. It hunts for
// the sync byte and deframes fixed 5-byte packets:
//
//   SYNC_BYTE, channel, voltage, current, checksum (= chan ^ volt ^ cur)
//
// Each good frame publishes its fields and a registered volt*cur power
// product. It also increments a wrapping frame counter and adds the power to
// a saturating energy accumulator. Bad checksums and inter-byte timeouts
// pulse their error flags and bump a saturating error counter.
//
// Parameters:
//   SYNC_BYTE       frame start marker
//   TIMEOUT_CYCLES  idle cycles tolerated between bytes inside a frame (1..255)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          block enable; when low no byte is accepted, timeout holds
//   rx_data      incoming telemetry byte
//   rx_valid     rx_data qualifier, one byte per cycle while high
//   energy_clr   synchronous clear of energy_acc (wins over a frame update)
//   frame_valid  one-cycle pulse, good frame published
//   chan         channel field of last good frame
//   volt         voltage field of last good frame
//   cur          current field of last good frame
//   power        volt*cur of last good frame, unsigned
//   energy_acc   saturating sum of power over good frames
//   frame_count  good-frame count, wraps
//   err_chk      one-cycle pulse on checksum mismatch
//   err_timeout  one-cycle pulse on inter-byte timeout
//   err_count    checksum + timeout events, saturates at 255
// -----------------------------------------------------------------------------
module energy_telemetry_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        energy_clr,
    output logic        frame_valid,
    output logic [7:0]  chan,
    output logic [7:0]  volt,
    output logic [7:0]  cur,
    output logic [15:0] power,
    output logic [23:0] energy_acc,
    output logic [7:0]  frame_count,
    output logic        err_chk,
    output logic        err_timeout,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        HUNT,
        CHAN,
        VOLT,
        CUR,
        CHK
    } state_t;

    // Timeout fires on the idle cycle that brings the count to TIMEOUT_CYCLES,
    // i.e. when the counter already holds TIMEOUT_CYCLES-1.
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] ENERGY_MAX   = 24'hFF_FFFF;
    localparam logic [7:0]  ERR_MAX      = 8'hFF;

    state_t      state;
    logic [7:0]  tcnt;

    // Shadow copies of the frame under construction; published only after
    // the checksum has been judged.
    logic [7:0]  chan_s;
    logic [7:0]  volt_s;
    logic [7:0]  cur_s;

    // Checksum verdict captured with the CHK byte; acted upon one edge later,
    // which gives the one-cycle publish latency.
    logic        good_pend;
    logic        bad_pend;

    logic        accept;
    logic        idle;
    logic        timeout_hit;
    logic [7:0]  chk_calc;
    logic [15:0] power_new;
    logic [24:0] energy_sum;
    logic [23:0] energy_next;

    // NOTE: every signal driven in always_comb gets a default first so a
    // missed branch can never infer a latch.
    always_comb begin
        accept      = rx_valid & ena;
        idle        = ena & ~rx_valid;
        timeout_hit = 1'b0;
        if (state != HUNT && idle && tcnt == TIMEOUT_LAST) begin
            timeout_hit = 1'b1;
        end

        chk_calc    = chan_s ^ volt_s ^ cur_s;
        power_new   = 16'(volt_s) * 16'(cur_s);

        // One extra bit catches the carry out of the 24-bit accumulator.
        energy_sum  = {1'b0, energy_acc} + 25'(power_new);
        energy_next = energy_sum[24] ? ENERGY_MAX : energy_sum[23:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value of every register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shadow registers are reset along with everything else.
        // They are only a few flops, and this keeps a stale partial frame
        // from ever surviving a reset.
        if (!rst_n) begin
            state       <= HUNT;
            tcnt        <= '0;
            chan_s      <= '0;
            volt_s      <= '0;
            cur_s       <= '0;
            good_pend   <= 1'b0;
            bad_pend    <= 1'b0;
            frame_valid <= 1'b0;
            chan        <= '0;
            volt        <= '0;
            cur         <= '0;
            power       <= '0;
            energy_acc  <= '0;
            frame_count <= '0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            // Pulses and pending verdicts default low every cycle.
            frame_valid <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            good_pend   <= 1'b0;
            bad_pend    <= 1'b0;

            // ---------------- deframing ----------------
            case (state)
                HUNT: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state <= CHAN;
                    end
                end
                CHAN: begin
                    if (accept) begin
                        chan_s <= rx_data;
                        state  <= VOLT;
                    end
                end
                VOLT: begin
                    if (accept) begin
                        volt_s <= rx_data;
                        state  <= CUR;
                    end
                end
                CUR: begin
                    if (accept) begin
                        cur_s <= rx_data;
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (rx_data == chk_calc) begin
                            good_pend <= 1'b1;
                        end else begin
                            bad_pend  <= 1'b1;
                        end
                        state <= HUNT;
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase

            // ---------------- inter-byte timeout ----------------
            // Only runs inside a frame. An accepted byte always clears it, so a
            // byte arriving on the limit cycle wins over the timeout. With ena
            // low neither branch is taken and the count holds.
            if (state == HUNT) begin
                tcnt <= '0;
            end else if (accept) begin
                tcnt <= '0;
            end else if (timeout_hit) begin
                tcnt        <= '0;
                state       <= HUNT;
                err_timeout <= 1'b1;
            end else if (idle) begin
                tcnt <= tcnt + 8'd1;
            end

            // ---------------- publication ----------------
            if (good_pend) begin
                chan        <= chan_s;
                volt        <= volt_s;
                cur         <= cur_s;
                power       <= power_new;
                frame_count <= frame_count + 8'd1;
                frame_valid <= 1'b1;
            end

            if (bad_pend) begin
                err_chk <= 1'b1;
            end

            // A checksum verdict is resolved while the FSM is outside CHAN..CHK
            // for that cycle, so both events never land on the same edge.
            if ((bad_pend || timeout_hit) && err_count != ERR_MAX) begin
                err_count <= err_count + 8'd1;
            end

            // The clear takes priority, so a coinciding frame's power is dropped.
            if (energy_clr) begin
                energy_acc <= '0;
            end else if (good_pend) begin
                energy_acc <= energy_next;
            end
        end
    end

endmodule

// File: tb/tb_energy_telemetry_rx.sv
// -----------------------------------------------------------------------------
// tb_energy_telemetry_rx
//
// Directed self-checking bench for energy_telemetry_rx. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, i.e. they
// reflect the state after the preceding edge.
// -----------------------------------------------------------------------------
module tb_energy_telemetry_rx;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        energy_clr;
    logic        frame_valid;
    logic [7:0]  chan;
    logic [7:0]  volt;
    logic [7:0]  cur;
    logic [15:0] power;
    logic [23:0] energy_acc;
    logic [7:0]  frame_count;
    logic        err_chk;
    logic        err_timeout;
    logic [7:0]  err_count;

    int checks;
    int errors;

    energy_telemetry_rx #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .energy_clr  (energy_clr),
        .frame_valid (frame_valid),
        .chan        (chan),
        .volt        (volt),
        .cur         (cur),
        .power       (power),
        .energy_acc  (energy_acc),
        .frame_count (frame_count),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input cycle, then land just after the edge that samples it.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] v,
                              input logic [7:0] i, input logic [7:0] k);
        step(1'b1, 8'hA5);
        step(1'b1, c);
        step(1'b1, v);
        step(1'b1, i);
        step(1'b1, k);
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset;
        rx_valid   = 1'b0;
        energy_clr = 1'b0;
        ena        = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %0h exp 0", frame_valid); end
        checks++; if (power !== 16'h0) begin errors++; $display("FAIL reset_power: got %0h exp 0", power); end
        checks++; if (energy_acc !== 24'h0) begin errors++; $display("FAIL reset_energy: got %0d exp 0", energy_acc); end
        checks++; if (frame_count !== 8'h0) begin errors++; $display("FAIL reset_fc: got %0d exp 0", frame_count); end
        checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL reset_ec: got %0d exp 0", err_count); end
        checks++; if ({chan, volt, cur} !== 24'h0) begin errors++; $display("FAIL reset_fields: got %0h exp 0", {chan, volt, cur}); end
        checks++; if ({err_chk, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %0b exp 00", {err_chk, err_timeout}); end
    endtask

    task automatic test_good_frame;
        send_frame(8'h01, 8'h96, 8'h55, 8'hC2);
        // The CHK byte was taken on the last edge; results must not be out yet.
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_early: got %0h exp 0", frame_valid); end
        step(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_fv: got %0h exp 1", frame_valid); end
        checks++; if ({chan, volt, cur} !== 24'h019655) begin errors++; $display("FAIL good_fields: got %0h exp 019655", {chan, volt, cur}); end
        checks++; if (power !== 16'h31CE) begin errors++; $display("FAIL good_power: got %0h exp 31ce", power); end
        checks++; if (energy_acc !== 24'd12750) begin errors++; $display("FAIL good_energy: got %0d exp 12750", energy_acc); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL good_fc: got %0d exp 1", frame_count); end
        checks++; if (err_count !== 8'd0 || err_chk !== 1'b0) begin errors++; $display("FAIL good_err: got %0d/%0b exp 0/0", err_count, err_chk); end
        step(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_fv_width: got %0h exp 0", frame_valid); end
    endtask

    task automatic test_bad_checksum;
        send_frame(8'h01, 8'h96, 8'h55, 8'hC3);
        step(1'b0, 8'h00);
        checks++; if (err_chk !== 1'b1) begin errors++; $display("FAIL bad_errchk: got %0h exp 1", err_chk); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bad_fv: got %0h exp 0", frame_valid); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_ec: got %0d exp 1", err_count); end
        checks++; if (power !== 16'h31CE || energy_acc !== 24'd12750) begin errors++; $display("FAIL bad_hold: got %0h/%0d exp 31ce/12750", power, energy_acc); end
        checks++; if (frame_count !== 8'd1 || {chan, volt, cur} !== 24'h019655) begin errors++; $display("FAIL bad_fields: got %0d/%0h exp 1/019655", frame_count, {chan, volt, cur}); end
        step(1'b0, 8'h00);
        checks++; if (err_chk !== 1'b0) begin errors++; $display("FAIL bad_errchk_width: got %0h exp 0", err_chk); end
    endtask

    task automatic test_hunt_timeout;
        // Junk bytes in HUNT are ignored; sync and one data byte open a frame.
        step(1'b1, 8'h00);
        step(1'b1, 8'h37);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 8'h00);
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got %0h exp 0", i, err_timeout); end
        end
        step(1'b0, 8'h00);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %0h exp 1", err_timeout); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL to_ec: got %0d exp 2", err_count); end
        // Back in HUNT the counter is idle, so a long gap raises nothing.
        repeat (20) step(1'b0, 8'h00);
        checks++; if (err_count !== 8'd2 || err_timeout !== 1'b0) begin errors++; $display("FAIL to_hunt_idle: got %0d/%0b exp 2/0", err_count, err_timeout); end
        // A fresh sync must be recognised, proving the FSM is in HUNT.
        send_frame(8'h02, 8'h10, 8'h20, 8'h32);
        step(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b1 || chan !== 8'h02) begin errors++; $display("FAIL to_resync: got %0b/%0h exp 1/02", frame_valid, chan); end
        checks++; if (power !== 16'h0200 || energy_acc !== 24'd13262 || frame_count !== 8'd2) begin errors++; $display("FAIL to_resync_vals: got %0h/%0d/%0d exp 0200/13262/2", power, energy_acc, frame_count); end
    endtask

    task automatic test_timeout_boundary;
        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        repeat (15) step(1'b0, 8'h00);
        // Byte lands on the 16th idle cycle: it wins, no timeout.
        step(1'b1, 8'h96);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tb_no_timeout: got %0h exp 0", err_timeout); end
        step(1'b1, 8'h55);
        step(1'b1, 8'hC2);
        step(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b1 || energy_acc !== 24'd26012 || frame_count !== 8'd3) begin errors++; $display("FAIL tb_frame: got %0b/%0d/%0d exp 1/26012/3", frame_valid, energy_acc, frame_count); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL tb_ec: got %0d exp 2", err_count); end
    endtask

    task automatic test_enable;
        // Scheduled pulse still fires with ena low.
        send_frame(8'h03, 8'h04, 8'h05, 8'h02);
        ena = 1'b0;
        step(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b1 || power !== 16'h0014 || energy_acc !== 24'd26032) begin errors++; $display("FAIL ena_pend: got %0b/%0h/%0d exp 1/0014/26032", frame_valid, power, energy_acc); end
        ena = 1'b1;
        // Timeout counter holds while ena is low; bytes offered then are ignored.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        repeat (10) step(1'b0, 8'h00);
        ena = 1'b0;
        repeat (20) step(1'b1, 8'h00);
        ena = 1'b1;
        for (int i = 11; i <= 15; i++) begin
            step(1'b0, 8'h00);
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL ena_hold_%0d: got %0h exp 0", i, err_timeout); end
        end
        step(1'b0, 8'h00);
        checks++; if (err_timeout !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL ena_timeout: got %0b/%0d exp 1/3", err_timeout, err_count); end
        checks++; if (frame_count !== 8'd4) begin errors++; $display("FAIL ena_fc: got %0d exp 4", frame_count); end
    endtask

    task automatic test_saturation;
        apply_reset();
        for (int i = 1; i <= 259; i++) begin
            send_frame(8'h00, 8'hFF, 8'hFF, 8'h00);
            step(1'b0, 8'h00);
            if (i == 258) begin
                checks++; if (power !== 16'hFE01) begin errors++; $display("FAIL sat_power: got %0h exp fe01", power); end
                checks++; if (energy_acc !== 24'd16776450) begin errors++; $display("FAIL sat_258: got %0d exp 16776450", energy_acc); end
                checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL sat_fc258: got %0d exp 2", frame_count); end
            end
        end
        checks++; if (energy_acc !== 24'd16777215) begin errors++; $display("FAIL sat_259: got %0d exp 16777215", energy_acc); end
        checks++; if (frame_count !== 8'd3 || frame_valid !== 1'b1) begin errors++; $display("FAIL sat_fc259: got %0d/%0b exp 3/1", frame_count, frame_valid); end
    endtask

    task automatic test_clear_collision;
        apply_reset();
        send_frame(8'h01, 8'h96, 8'h55, 8'hC2);
        energy_clr = 1'b1;
        step(1'b0, 8'h00);
        energy_clr = 1'b0;
        checks++; if (energy_acc !== 24'd0) begin errors++; $display("FAIL clr_energy: got %0d exp 0", energy_acc); end
        checks++; if (frame_valid !== 1'b1 || frame_count !== 8'd1 || power !== 16'h31CE) begin errors++; $display("FAIL clr_frame: got %0b/%0d/%0h exp 1/1/31ce", frame_valid, frame_count, power); end
        send_frame(8'h02, 8'h10, 8'h20, 8'h32);
        step(1'b0, 8'h00);
        checks++; if (energy_acc !== 24'd512 || frame_count !== 8'd2) begin errors++; $display("FAIL clr_after: got %0d/%0d exp 512/2", energy_acc, frame_count); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        send_frame(8'h01, 8'h96, 8'h55, 8'hC2);
        // Next sync follows immediately; the first frame publishes on that edge.
        step(1'b1, 8'hA5);
        checks++; if (frame_valid !== 1'b1 || chan !== 8'h01) begin errors++; $display("FAIL b2b_first: got %0b/%0h exp 1/01", frame_valid, chan); end
        step(1'b1, 8'h02);
        step(1'b1, 8'h10);
        step(1'b1, 8'h20);
        step(1'b1, 8'h32);
        step(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b1 || {chan, volt, cur} !== 24'h021020) begin errors++; $display("FAIL b2b_second: got %0b/%0h exp 1/021020", frame_valid, {chan, volt, cur}); end
        checks++; if (energy_acc !== 24'd13262 || frame_count !== 8'd2 || power !== 16'h0200) begin errors++; $display("FAIL b2b_vals: got %0d/%0d/%0h exp 13262/2/0200", energy_acc, frame_count, power); end
    endtask

    task automatic test_reset_mid_frame;
        // Outputs are non-zero from the previous scenario.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        rst_n = 1'b0;
        #2;
        checks++; if (energy_acc !== 24'd0 || frame_count !== 8'd0 || power !== 16'h0) begin errors++; $display("FAIL mid_rst_async: got %0d/%0d/%0h exp 0/0/0", energy_acc, frame_count, power); end
        checks++; if ({chan, volt, cur} !== 24'h0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_fields: got %0h/%0d exp 0/0", {chan, volt, cur}, err_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h96);
        step(1'b1, 8'h55);
        step(1'b1, 8'hC2);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00);
            checks++; if ({frame_valid, err_chk, err_timeout} !== 3'b000) begin errors++; $display("FAIL mid_rst_quiet_%0d: got %0b exp 000", i, {frame_valid, err_chk, err_timeout}); end
        end
        checks++; if (frame_count !== 8'd0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_counts: got %0d/%0d exp 0/0", frame_count, err_count); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        energy_clr = 1'b0;

        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_hunt_timeout();
        test_timeout_boundary();
        test_enable();
        test_saturation();
        test_clear_collision();
        test_back_to_back();
        test_reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/energy_telemetry_rx.md
Name: energy_telemetry_rx

Overview:
- Host-side receiver for the converter's telemetry byte stream. It is the consuming end of the sample/telemetry interface the converter top level emits.
- Hunts for a sync byte, deframes fixed 5-byte packets (sync, channel, voltage, current, checksum) and validates the XOR checksum.
- Publishes registered channel, voltage and current fields plus a 16-bit power product, and keeps a saturating energy accumulator, a frame counter and an error counter.
- Sits between the converter's output bus and the host monitoring logic.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 16, maximum idle cycles allowed between bytes inside a frame; range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; when low, rx_valid is ignored and the timeout counter holds
- rx_data  in  8  incoming telemetry byte
- rx_valid  in  1  rx_data qualifier; one byte is accepted per cycle while high
- energy_clr  in  1  synchronous clear of energy_acc
- frame_valid  out  1  one-cycle pulse: good frame published
- chan  out  8  channel field of last good frame
- volt  out  8  voltage field of last good frame
- cur  out  8  current field of last good frame
- power  out  16  volt*cur of last good frame, unsigned
- energy_acc  out  24  saturating sum of power over good frames
- frame_count  out  8  good-frame count, wraps 255->0
- err_chk  out  1  one-cycle pulse on checksum mismatch
- err_timeout  out  1  one-cycle pulse on inter-byte timeout
- err_count  out  8  err_chk plus err_timeout events, saturates at 255

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs go to 0, the FSM goes to HUNT and the timeout counter clears. Reset mid-frame discards the partial frame.
- Byte accepted = rx_valid & ena on a rising edge.
- FSM states: HUNT, CHAN, VOLT, CUR, CHK.
  - HUNT: an accepted byte equal to SYNC_BYTE -> CHAN; any other byte is ignored.
  - CHAN/VOLT/CUR: the accepted byte is captured into a shadow register, then advance to the next state.
  - CHK: the accepted byte is compared with chan_s^volt_s^cur_s, then -> HUNT.
  - SYNC_BYTE appearing inside a frame is treated as data; it never resyncs.
- Good checksum, effective at the edge after the CHK byte:
  - chan/volt/cur take the shadow values; power = volt_s*cur_s (registered).
  - frame_valid=1 for exactly one cycle.
  - frame_count increments.
  - energy_acc = min(energy_acc + power_new, 2^24-1).
  - Latency: CHK byte at edge N -> outputs visible after edge N+1.
- Bad checksum:
  - err_chk=1 for one cycle at the same latency as frame_valid.
  - err_count increments, saturating at 255.
  - All published fields, power, energy_acc and frame_count hold.
- Timeout:
  - In CHAN..CHK, the counter increments each cycle with no accepted byte and clears on every accepted byte.
  - When the count reaches TIMEOUT_CYCLES: err_timeout pulses for one cycle, err_count increments, the FSM returns to HUNT and the counter clears.
  - If a byte arrives in the same cycle the limit is reached, the byte wins and there is no timeout.
  - The counter does not run in HUNT.
- ena low: no byte is accepted and the timeout counter holds. energy_clr still acts. Pulses already scheduled still fire.
- energy_clr: energy_acc <= 0. If it coincides with a good-frame update, clear wins and that frame's power is not added; frame_count and the fields still update.
- frame_valid and err_chk are mutually exclusive. err_timeout cannot coincide with either, because a frame's result pulse occurs only after the FSM has left CHK.

Test Plan:
- Good frame: bytes A5 01 96 55 C2, one per cycle -> after the edge following C2, frame_valid pulses; chan=01, volt=96h (150), cur=55h (85), power=31CEh (12750), energy_acc=12750, frame_count=1, err_count=0.
- Bad checksum: A5 01 96 55 C3 after the good frame -> err_chk pulses, err_count=1; fields, power=31CEh, energy_acc=12750 and frame_count=1 all unchanged.
- Hunt and timeout:
  - Bytes 00 37 A5 01, then idle 16 cycles -> 00/37 ignored; err_timeout pulses on the 16th idle cycle; FSM back in HUNT; err_count increments.
  - Repeat with a byte at idle cycle 16 -> no timeout.
- Saturation and wrap: 259 frames A5 00 FF FF 00 -> power=FE01h; energy_acc=16776450 after frame 258 and 16777215 after frame 259; frame_count=3.
- Clear collision: assert energy_clr on the same edge a good frame publishes -> energy_acc=0, frame_count still increments, frame_valid pulses.
- Reset mid-frame: rst_n low during VOLT after A5 01 -> all outputs 0. Then bytes 96 55 C2 with no sync -> no frame_valid, no errors.
